// File: rtl/dec_pkg.sv
// Shared types and constants for the sequenced one-hot decoder.
// Holds the FSM state encoding, the default timing and the reference decode function.
package dec_pkg;

  localparam int DEC_CODE_W    = 2;
  localparam int DEC_OUT_W     = 2 ** DEC_CODE_W;
  localparam int DEC_PULSE_LEN = 4;
  localparam int DEC_GAP_LEN   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } dec_state_e;

  function automatic logic [DEC_OUT_W-1:0] onehot_dec(input logic [DEC_CODE_W-1:0] code);
    logic [DEC_OUT_W-1:0] res;
    res       = '0;
    res[code] = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational CODE_W-to-2**CODE_W decoder with enable; inverse of the 4x2 encoder.
// A disabled decode produces all zeros, so the output is always one-hot or zero.
module dec_onehot
  import dec_pkg::*;
#(
  parameter int  CODE_W = DEC_CODE_W,
  localparam int OUT_W  = 2 ** CODE_W
) (
  input  logic [CODE_W-1:0] code,
  input  logic              en,
  output logic [OUT_W-1:0]  y
);

  // The common 2-bit case reuses the shared package function.
  if (CODE_W == DEC_CODE_W) begin : g_pkg
    assign y = en ? onehot_dec(code) : '0;
  end else begin : g_generic
    always_comb begin
      y = '0;
      if (en) y[code] = 1'b1;
    end
  end

endmodule

// File: rtl/dec2x4_pulse_gen.sv
// Sequenced 2-to-4 decoder: accepts a code over valid/ready, drives the matching
// one-hot strobe for PULSE_LEN cycles, then idles GAP_LEN cycles before the next code.
module dec2x4_pulse_gen
  import dec_pkg::*;
#(
  parameter int  CODE_W    = DEC_CODE_W,
  parameter int  PULSE_LEN = DEC_PULSE_LEN,
  parameter int  GAP_LEN   = DEC_GAP_LEN,
  localparam int OUT_W     = 2 ** CODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_en,
  output logic [OUT_W-1:0]  y,
  output logic              y_valid,
  output logic              busy,
  output logic              done
);

  localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = ($clog2(MAX_LEN + 1) < 1) ? 1 : $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  if (PULSE_LEN < 1) begin : g_bad_pulse_len
    $fatal(1, "dec2x4_pulse_gen: PULSE_LEN must be >= 1");
  end
  if (GAP_LEN < 0) begin : g_bad_gap_len
    $fatal(1, "dec2x4_pulse_gen: GAP_LEN must be >= 0");
  end

  dec_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic               y_valid_q, y_valid_d;
  logic               done_q, done_d;
  logic [OUT_W-1:0]   dec_y;

  dec_onehot #(.CODE_W(CODE_W)) u_dec (
    .code (in_code),
    .en   (in_en),
    .y    (dec_y)
  );

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign y        = y_q;
  assign y_valid  = y_valid_q;
  assign done     = done_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone marks an accept.
        if (in_valid) begin
          state_d   = PULSE;
          cnt_d     = PULSE_LOAD;
          y_d       = dec_y;
          y_valid_d = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          y_d       = '0;
          y_valid_d = 1'b0;
          done_d    = 1'b1;
          if (GAP_LEN > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        y_d       = '0;
        y_valid_d = 1'b0;
      end
    endcase
  end

  // Reset drops any in-flight transaction without raising done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      done_q    <= done_d;
    end
  end

  a_y_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(y_q));
  a_done_outside_window: assert property (@(posedge clk) disable iff (!rst_n) done_q |-> !y_valid_q);
  a_y_only_in_window: assert property (@(posedge clk) disable iff (!rst_n) !y_valid_q |-> (y_q == '0));

endmodule

// File: tb/tb_dec2x4_pulse_gen.sv
// Scoreboard bench for dec2x4_pulse_gen: two instances (default timing and PULSE_LEN=1/GAP_LEN=0)
// driven by directed and random stimulus; expectations come from a transaction-level model.
module tb_dec2x4_pulse_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] y;
    int         acc;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_t
    localparam int P = (k == 0) ? 4 : 1;
    localparam int G = (k == 0) ? 1 : 0;

    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_code;
    logic       in_en;
    logic [3:0] y;
    logic       y_valid;
    logic       busy;
    logic       done;

    exp_t sbq[$];
    int   cyc      = 0;
    int   free_c   = 0;
    int   acc_cnt  = 0;
    int   done_cnt = 0;
    int   dropped  = 0;
    bit   fin_k    = 1'b0;

    dec2x4_pulse_gen #(.CODE_W(2), .PULSE_LEN(P), .GAP_LEN(G)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_code  (in_code),
      .in_en    (in_en),
      .y        (y),
      .y_valid  (y_valid),
      .busy     (busy),
      .done     (done)
    );

    function automatic logic [3:0] ref_y(input logic [1:0] c, input logic e);
      return e ? (4'd1 << c) : 4'd0;
    endfunction

    // One clock cycle: check handshake against the model, drive inputs, record any accept.
    task automatic drive_cycle(input bit v, input logic [1:0] c, input bit e);
      @(negedge clk);
      check($sformatf("in_ready[%0d]", k), in_ready, cyc >= free_c);
      check($sformatf("busy[%0d]", k), busy, cyc < free_c);
      in_valid = v;
      in_code  = c;
      in_en    = e;
      @(posedge clk);
      if (v && cyc >= free_c) begin
        sbq.push_back('{y: ref_y(c, e), acc: cyc});
        acc_cnt++;
        free_c = cyc + P + G + 1;
      end
      cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
      check($sformatf("%s_y[%0d]", tag, k), y, 4'd0);
      check($sformatf("%s_y_valid[%0d]", tag, k), y_valid, 1'b0);
      check($sformatf("%s_busy[%0d]", tag, k), busy, 1'b0);
      check($sformatf("%s_done[%0d]", tag, k), done, 1'b0);
      check($sformatf("%s_in_ready[%0d]", tag, k), in_ready, 1'b1);
    endtask

    task automatic apply_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      in_valid = 1'b0;
      #1 check_reset_outputs("rst");
      dropped += sbq.size();
      sbq.delete();
      free_c = 0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      cyc++;
    endtask

    // Monitor: compares outputs every cycle against the window of the oldest outstanding accept.
    always @(negedge clk) begin : mon
      logic [3:0] ey;
      logic       ev;
      logic       ed;
      int         d;
      if (rst_n === 1'b1) begin
        ey = 4'd0;
        ev = 1'b0;
        ed = 1'b0;
        if (sbq.size() > 0) begin
          d = cyc - sbq[0].acc;
          if (d >= 1 && d <= P) begin
            ev = 1'b1;
            ey = sbq[0].y;
          end else if (d == P + 1) begin
            ed = 1'b1;
          end
        end
        check($sformatf("y[%0d]", k), y, ey);
        check($sformatf("y_valid[%0d]", k), y_valid, ev);
        check($sformatf("done[%0d]", k), done, ed);
        check($sformatf("onehot0[%0d]", k), ($countones(y) <= 1), 1'b1);
        if (done === 1'b1) done_cnt++;
        if (ed) void'(sbq.pop_front());
      end
    end

    initial begin
      int a0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_code  = 2'd0;
      in_en    = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("init");
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      cyc++;

      // Single decode of code 2, then let the window and guard run out.
      drive_cycle(1'b1, 2'd2, 1'b1);
      repeat (P + G + 2) drive_cycle(1'b0, 2'd0, 1'b0);

      // Sweep all codes with in_valid held high.
      for (int c = 0; c < 4; c++) begin
        a0 = acc_cnt;
        for (int n = 0; n < 20 && acc_cnt == a0; n++) drive_cycle(1'b1, 2'(c), 1'b1);
      end
      repeat (P + G + 2) drive_cycle(1'b0, 2'd0, 1'b0);

      // Disabled decode still produces a full window.
      drive_cycle(1'b1, 2'd3, 1'b0);
      repeat (P + G + 2) drive_cycle(1'b0, 2'd0, 1'b0);

      // Random traffic, including code/enable churn and in_valid while busy.
      repeat (300) drive_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                               ($urandom_range(0, 3) != 0));
      repeat (P + G + 2) drive_cycle(1'b0, 2'd0, 1'b0);

      // Reset in the second pulse cycle drops the transaction.
      drive_cycle(1'b1, 2'd1, 1'b1);
      drive_cycle(1'b0, 2'd0, 1'b0);
      apply_reset();
      drive_cycle(1'b1, 2'd0, 1'b1);
      repeat (P + G + 2) drive_cycle(1'b0, 2'd0, 1'b0);

      check($sformatf("done_count[%0d]", k), done_cnt, acc_cnt - dropped);
      check($sformatf("sb_empty[%0d]", k), sbq.size(), 0);
      fin_k = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(g_t[0].fin_k && g_t[1].fin_k) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("timeout", (g_t[0].fin_k && g_t[1].fin_k), 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
